// File: rtl/mem_access_stage_pkg.sv
// Shared MEM-stage definitions: access size encodings,
// default widths and the alignment-fault helper.
package mem_access_stage_pkg;

    localparam logic [1:0] MEM_NONE = 2'b00;
    localparam logic [1:0] MEM_B    = 2'b01;
    localparam logic [1:0] MEM_H    = 2'b10;
    localparam logic [1:0] MEM_W    = 2'b11;

    localparam int DW_DEF = 32;
    localparam int RW_DEF = 5;

    // Half needs addr[0]==0, word needs addr[1:0]==0.
    function automatic logic misaligned(
        input logic [1:0] size,
        input logic [1:0] off
    );
        logic bad;
        bad = 1'b0;
        if (size == MEM_H) bad = off[0];
        if (size == MEM_W) bad = |off;
        return bad;
    endfunction

endpackage

// File: rtl/mem_access_stage_store_align.sv
// store_align: byte-lane alignment of store data.
// Ports: size/off/busB in -> wen (4 lanes), wdata out.
module store_align
    import mem_access_stage_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic [1:0]    size,
    input  logic [1:0]    off,
    input  logic [DW-1:0] busB,
    output logic [3:0]    wen,
    output logic [DW-1:0] wdata
);

    always_comb begin
        wen   = 4'b0000;
        wdata = busB << {off, 3'b000};
        unique case (size)
            MEM_B: wen = 4'b0001 << off;
            MEM_H: begin
                unique case (off)
                    2'b00:   wen = 4'b0011;
                    2'b01:   wen = 4'b0110;
                    2'b10:   wen = 4'b1100;
                    default: wen = 4'b0000;
                endcase
            end
            MEM_W: begin
                wen   = 4'b1111;
                wdata = busB;
            end
            default: wen = 4'b0000;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: EX->MEM register, data-SRAM request, and a
// read-data hold buffer covering WB back-pressure.
// Ports: es_* in from EX, ms_* out to WB, data_sram_* to
// the synchronous SRAM, ws_allowin/ms_allowin handshake.
// Optional ADDR_EXC_EN: alignment check adds ms_ade and
// ms_badvaddr and suppresses misaligned requests.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int RW = RW_DEF
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          es_to_ms_valid,
    output logic          ms_allowin,
    input  logic [DW-1:0] es_aluResult,
    input  logic [DW-1:0] es_busB,
    input  logic [1:0]    es_memR,
    input  logic [1:0]    es_memW,
    input  logic          es_regWrite,
    input  logic [RW-1:0] es_rd,
    input  logic [DW-1:0] es_pc,
    input  logic          ws_allowin,
    output logic          ms_to_ws_valid,
    output logic [DW-1:0] ms_aluResult,
    output logic [1:0]    ms_memR,
    output logic          ms_regWrite,
    output logic [RW-1:0] ms_rd,
    output logic [DW-1:0] ms_pc,
    output logic [DW-1:0] ms_rdata_raw,
`ifdef ADDR_EXC_EN
    output logic          ms_ade,
    output logic [DW-1:0] ms_badvaddr,
`endif
    output logic          data_sram_en,
    output logic [3:0]    data_sram_wen,
    output logic [DW-1:0] data_sram_addr,
    output logic [DW-1:0] data_sram_wdata,
    input  logic [DW-1:0] data_sram_rdata
);

    logic          msValid;
    logic          rdHold;
    logic [DW-1:0] holdReg;
    logic          enter;
    logic          isMem;
    logic          fire;
    logic [3:0]    alignWen;
    logic [DW-1:0] alignWdata;
    logic          adErr;

    assign ms_allowin     = !msValid || ws_allowin;
    assign ms_to_ws_valid = msValid;
    assign enter          = es_to_ms_valid && ms_allowin;
    assign isMem = (es_memR != MEM_NONE) ||
                   (es_memW != MEM_NONE);

`ifdef ADDR_EXC_EN
    assign adErr =
        misaligned(es_memR, es_aluResult[1:0]) ||
        misaligned(es_memW, es_aluResult[1:0]);
`else
    assign adErr = 1'b0;
`endif

    assign fire = enter && isMem && !adErr;

    store_align #(.DW(DW)) uAlign (
        .size  (es_memW),
        .off   (es_aluResult[1:0]),
        .busB  (es_busB),
        .wen   (alignWen),
        .wdata (alignWdata)
    );

    assign data_sram_en    = fire;
    assign data_sram_wen   = fire ? alignWen : 4'b0000;
    assign data_sram_addr  = es_aluResult;
    assign data_sram_wdata = alignWdata;

    // SRAM word arrives in the first MEM cycle only;
    // after that the captured copy stands in for it.
    assign ms_rdata_raw = rdHold ? holdReg
                                 : data_sram_rdata;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            msValid <= 1'b0;
        end else if (ms_allowin) begin
            msValid <= es_to_ms_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ms_aluResult <= '0;
            ms_memR      <= MEM_NONE;
            ms_regWrite  <= 1'b0;
            ms_rd        <= '0;
            ms_pc        <= '0;
        end else if (enter) begin
            ms_aluResult <= es_aluResult;
            ms_memR      <= es_memR;
            ms_regWrite  <= es_regWrite;
            ms_rd        <= es_rd;
            ms_pc        <= es_pc;
        end
    end

`ifdef ADDR_EXC_EN
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ms_ade      <= 1'b0;
            ms_badvaddr <= '0;
        end else if (enter) begin
            ms_ade      <= isMem && adErr;
            ms_badvaddr <= (isMem && adErr) ?
                           es_aluResult : '0;
        end
    end
`endif

    // !ms_allowin means an instruction is stuck in MEM;
    // any allowin cycle either empties MEM or refills it.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rdHold  <= 1'b0;
            holdReg <= '0;
        end else begin
            rdHold <= !ms_allowin;
            if (msValid && !rdHold) begin
                holdReg <= data_sram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage with an
// abstract SRAM and stage model.
module tb_mem_access_stage;

    localparam int DW = 32;
    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          es_to_ms_valid = 1'b0;
    logic          ms_allowin;
    logic [DW-1:0] es_aluResult = '0;
    logic [DW-1:0] es_busB = '0;
    logic [1:0]    es_memR = 2'b00;
    logic [1:0]    es_memW = 2'b00;
    logic          es_regWrite = 1'b0;
    logic [RW-1:0] es_rd = '0;
    logic [DW-1:0] es_pc = '0;
    logic          ws_allowin = 1'b1;
    logic          ms_to_ws_valid;
    logic [DW-1:0] ms_aluResult;
    logic [1:0]    ms_memR;
    logic          ms_regWrite;
    logic [RW-1:0] ms_rd;
    logic [DW-1:0] ms_pc;
    logic [DW-1:0] ms_rdata_raw;
`ifdef ADDR_EXC_EN
    logic          ms_ade;
    logic [DW-1:0] ms_badvaddr;
`endif
    logic          data_sram_en;
    logic [3:0]    data_sram_wen;
    logic [DW-1:0] data_sram_addr;
    logic [DW-1:0] data_sram_wdata;
    logic [DW-1:0] data_sram_rdata = '0;

    int checks = 0;
    int fails  = 0;

    mem_access_stage #(.DW(DW), .RW(RW)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .es_to_ms_valid  (es_to_ms_valid),
        .ms_allowin      (ms_allowin),
        .es_aluResult    (es_aluResult),
        .es_busB         (es_busB),
        .es_memR         (es_memR),
        .es_memW         (es_memW),
        .es_regWrite     (es_regWrite),
        .es_rd           (es_rd),
        .es_pc           (es_pc),
        .ws_allowin      (ws_allowin),
        .ms_to_ws_valid  (ms_to_ws_valid),
        .ms_aluResult    (ms_aluResult),
        .ms_memR         (ms_memR),
        .ms_regWrite     (ms_regWrite),
        .ms_rd           (ms_rd),
        .ms_pc           (ms_pc),
        .ms_rdata_raw    (ms_rdata_raw),
`ifdef ADDR_EXC_EN
        .ms_ade          (ms_ade),
        .ms_badvaddr     (ms_badvaddr),
`endif
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .data_sram_rdata (data_sram_rdata)
    );

    always #5 clk = ~clk;

    // Memory contents as a pure function of the address.
    function automatic logic [31:0] memWord(
        input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h12345678;
    endfunction

    // One-cycle-latency SRAM; garbage when idle.
    always @(posedge clk) begin
        if (data_sram_en)
            data_sram_rdata <= memWord(data_sram_addr);
        else
            data_sram_rdata <= $urandom;
    end

    function automatic int nBytes(input logic [1:0] s);
        return (s == 2'b01) ? 1 : (s == 2'b10) ? 2 : 4;
    endfunction

    // Lane model: bytes [base, base+n) of the word;
    // word stores ignore the offset; overflow drops.
    function automatic logic [3:0] refWen(
        input logic [1:0] s, input logic [31:0] a);
        int n, base;
        if (s == 2'b00) return 4'b0000;
        n = nBytes(s);
        base = (s == 2'b11) ? 0 : int'(a[1:0]);
        if (base + n > 4) return 4'b0000;
        return 4'(((1 << n) - 1) << base);
    endfunction

    function automatic logic [31:0] refWdata(
        input logic [1:0] s, input logic [31:0] a,
        input logic [31:0] b);
        int base;
        base = (s == 2'b11) ? 0 : int'(a[1:0]);
        return b << (8 * base);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        es_to_ms_valid = 1'b0;
        es_memR = 2'b00;
        es_memW = 2'b00;
    endtask

    task automatic drive(input logic [1:0] r,
        input logic [1:0] w, input logic [31:0] a,
        input logic [31:0] b, input logic [31:0] pc);
        es_to_ms_valid = 1'b1;
        es_memR = r;
        es_memW = w;
        es_aluResult = a;
        es_busB = b;
        es_pc = pc;
        es_rd = RW'(pc[6:2]);
        es_regWrite = (r != 2'b00);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        idle();
        ws_allowin = 1'b1;
        tick();
        tick();
        checks++;
        if (ms_to_ws_valid !== 1'b0 || ms_allowin !== 1'b1) begin
            fails++;
            $display("FAIL reset_hs: valid=%b allowin=%b need 0/1",
                ms_to_ws_valid, ms_allowin);
        end
        checks++;
        if ({ms_aluResult, ms_memR, ms_regWrite,
             ms_rd, ms_pc} !== '0) begin
            fails++;
            $display("FAIL reset_regs: alu=%h pc=%h rd=%h need 0",
                ms_aluResult, ms_pc, ms_rd);
        end
        resetn = 1'b1;
        tick();
    endtask

    task automatic checkStore(input string nm,
        input logic [1:0] w, input logic [31:0] a,
        input logic [31:0] b);
        logic [3:0] ew;
        drive(2'b00, w, a, b, 32'h400);
        #3;
        ew = refWen(w, a);
        checks++;
        if (data_sram_en !== 1'b1 || data_sram_wen !== ew ||
            data_sram_addr !== a) begin
            fails++;
            $display("FAIL %s: en=%b wen=%b addr=%h need 1/%b/%h",
                nm, data_sram_en, data_sram_wen,
                data_sram_addr, ew, a);
        end
        if (ew != 4'b0000) begin
            checks++;
            if (data_sram_wdata !== refWdata(w, a, b)) begin
                fails++;
                $display("FAIL %s_wdata: got %h need %h", nm,
                    data_sram_wdata, refWdata(w, a, b));
            end
        end
        tick();
    endtask

    task automatic test_store_lanes();
        logic [31:0] a;
        logic [1:0]  w;
        ws_allowin = 1'b1;
        checkStore("sw", 2'b11, 32'h100, 32'hDEADBEEF);
        checkStore("sb", 2'b01, 32'h103, 32'h000000AB);
        checkStore("sh", 2'b10, 32'h102, 32'h0000CAFE);
        checkStore("sh_lo", 2'b10, 32'h100, 32'h00001234);
        for (int i = 0; i < 24; i++) begin
            w = 2'($urandom_range(1, 3));
            a = $urandom & 32'h0000FFFF;
`ifdef ADDR_EXC_EN
            if (w == 2'b10) a[0] = 1'b0;
            if (w == 2'b11) a[1:0] = 2'b00;
`endif
            checkStore("st_rand", w, a, $urandom);
        end
        idle();
        #3;
        checks++;
        if (data_sram_en !== 1'b0 || data_sram_wen !== 4'b0) begin
            fails++;
            $display("FAIL no_req: en=%b wen=%b need 0/0000",
                data_sram_en, data_sram_wen);
        end
        tick();
    endtask

    task automatic test_load_hold();
        logic [31:0] exp;
        exp = memWord(32'h0);
        ws_allowin = 1'b0;
        drive(2'b11, 2'b00, 32'h0, 32'h0, 32'h500);
        #3;
        checks++;
        if (data_sram_en !== 1'b1 || data_sram_wen !== 4'b0) begin
            fails++;
            $display("FAIL lw_req: en=%b wen=%b need 1/0000",
                data_sram_en, data_sram_wen);
        end
        tick();
        idle();
        for (int c = 0; c < 4; c++) begin
            ws_allowin = (c == 3);
            #3;
            checks++;
            if (ms_rdata_raw !== exp) begin
                fails++;
                $display("FAIL hold_c%0d: raw=%h need %h",
                    c, ms_rdata_raw, exp);
            end
            checks++;
            if (ms_to_ws_valid !== 1'b1 ||
                ms_allowin !== (c == 3)) begin
                fails++;
                $display("FAIL hold_hs%0d: v=%b al=%b", c,
                    ms_to_ws_valid, ms_allowin);
            end
            tick();
        end
        ws_allowin = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] prev;
        logic [31:0] a;
        ws_allowin = 1'b1;
        prev = 32'h0;
        for (int i = 0; i < 12; i++) begin
            a = $urandom & 32'h0000FFFC;
            drive(2'b11, 2'b00, a, 32'h0, 32'h1000 + 4 * i);
            #3;
            if (i > 0) begin
                checks++;
                if (ms_rdata_raw !== memWord(prev) ||
                    ms_aluResult !== prev) begin
                    fails++;
                    $display("FAIL b2b%0d: raw=%h need %h",
                        i, ms_rdata_raw, memWord(prev));
                end
            end
            prev = a;
            tick();
        end
        idle();
        #3;
        checks++;
        if (ms_rdata_raw !== memWord(prev)) begin
            fails++;
            $display("FAIL b2b_last: raw=%h need %h",
                ms_rdata_raw, memWord(prev));
        end
        tick();
    endtask

    task automatic test_random_handshake();
        logic        mV;
        logic [31:0] mA, mPc;
        logic [1:0]  mR;
        logic        eV, wA, al, isM;
        logic [1:0]  r, w;
        logic [31:0] a;
        int          k;
        mV = 1'b0;
        mA = '0; mPc = '0; mR = '0;
        for (int i = 0; i < 200; i++) begin
            eV = 1'($urandom_range(0, 1));
            wA = ($urandom_range(0, 2) != 0);
            k  = $urandom_range(0, 2);
            r  = (k == 1) ? 2'($urandom_range(1, 3)) : 2'b00;
            w  = (k == 2) ? 2'($urandom_range(1, 3)) : 2'b00;
            a  = $urandom & 32'h0000FFFC;
            drive(r, w, a, $urandom, 32'h8000 + 4 * i);
            es_to_ms_valid = eV;
            ws_allowin = wA;
            #3;
            al  = !mV || wA;
            isM = (r != 0) || (w != 0);
            checks++;
            if (ms_allowin !== al || ms_to_ws_valid !== mV ||
                data_sram_en !== (eV && al && isM)) begin
                fails++;
                $display("FAIL hs%0d: al=%b v=%b en=%b need %b/%b/%b",
                    i, ms_allowin, ms_to_ws_valid, data_sram_en,
                    al, mV, eV && al && isM);
            end
            if (mV) begin
                checks++;
                if (ms_pc !== mPc || ms_memR !== mR) begin
                    fails++;
                    $display("FAIL regs%0d: pc=%h need %h", i,
                        ms_pc, mPc);
                end
                if (mR != 2'b00) begin
                    checks++;
                    if (ms_rdata_raw !== memWord(mA)) begin
                        fails++;
                        $display("FAIL rnd_raw%0d: %h need %h",
                            i, ms_rdata_raw, memWord(mA));
                    end
                end
            end
            if (al) begin
                mV = eV;
                if (eV) begin
                    mA = a;
                    mPc = 32'h8000 + 4 * i;
                    mR = r;
                end
            end
            tick();
        end
        idle();
        ws_allowin = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        ws_allowin = 1'b0;
        drive(2'b11, 2'b00, 32'h40, 32'h0, 32'h600);
        tick();
        idle();
        resetn = 1'b0;
        tick();
        checks++;
        if (ms_to_ws_valid !== 1'b0 || ms_pc !== '0 ||
            ms_aluResult !== '0 || ms_memR !== 2'b00 ||
            ms_regWrite !== 1'b0 || ms_rd !== '0) begin
            fails++;
            $display("FAIL rst_mid: v=%b pc=%h alu=%h need 0",
                ms_to_ws_valid, ms_pc, ms_aluResult);
        end
        resetn = 1'b1;
        tick();
        checks++;
        if (ms_to_ws_valid !== 1'b0 || ms_allowin !== 1'b1) begin
            fails++;
            $display("FAIL rst_after: v=%b al=%b need 0/1",
                ms_to_ws_valid, ms_allowin);
        end
        ws_allowin = 1'b1;
    endtask

    task automatic test_misalign();
        ws_allowin = 1'b1;
        drive(2'b11, 2'b00, 32'h101, 32'h0, 32'h700);
        #3;
        checks++;
`ifdef ADDR_EXC_EN
        if (data_sram_en !== 1'b0 || data_sram_wen !== 4'b0) begin
            fails++;
            $display("FAIL ade_en: en=%b need 0", data_sram_en);
        end
        tick();
        idle();
        checks++;
        if (ms_ade !== 1'b1 || ms_badvaddr !== 32'h101) begin
            fails++;
            $display("FAIL ade: ade=%b bad=%h need 1/101",
                ms_ade, ms_badvaddr);
        end
`else
        if (data_sram_en !== 1'b1) begin
            fails++;
            $display("FAIL mis_en: en=%b need 1", data_sram_en);
        end
        tick();
        idle();
        checkStore("sh_drop", 2'b10, 32'h103, 32'h0000BEEF);
`endif
        idle();
        tick();
    endtask

    initial begin
        test_reset();
        test_store_lanes();
        test_load_hold();
        test_back_to_back();
        test_random_handshake();
        test_reset_mid();
        test_misalign();
        $display("End of test - %0d assertions evaluated, %0d failures",
            checks, fails);
        $finish;
    end

endmodule
